// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [NUM_DIGITS-1:0] digit_sel_t;

  localparam digit_sel_t SEL_FIRST  = 4'b0001;
  localparam digit_sel_t ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {
    BLANK,
    SHOW,
    HOLD
  } scan_state_t;

  function automatic logic is_onehot(digit_sel_t v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic digit_sel_t rotate_left(digit_sel_t v);
    return {v[NUM_DIGITS-2:0], v[NUM_DIGITS-1]};
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Modulus-MODULUS up-counter with synchronous clear and terminal-count flag.
module slot_counter #(
  parameter int unsigned MODULUS = 8,
  localparam int unsigned WIDTH  = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit scan: rotating one-hot selector, blanked active-low
// anodes and a frame-start strobe on each wrap back to digit 0.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 2_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_enable,
  output logic [NUM_DIGITS-1:0] selector,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_start
);

  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  // Last count of the blank window; the anode register loads here for the first lit cycle.
  localparam logic [CW-1:0] SHOW_FROM = CW'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_params
    $error("display_scan_controller: need 1 <= BLANK_CYCLES < DWELL_CYCLES");
  end

  scan_state_t           state;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  fs_q;

  logic [CW-1:0]         count;
  logic                  tc;
  logic                  sel_ok;
  logic                  cnt_inc;
  logic                  cnt_clr;
  logic [NUM_DIGITS-1:0] mask_eff;

  assign sel_ok  = is_onehot(sel_q);
  assign cnt_inc = sel_ok && en && (state != HOLD);
  assign cnt_clr = !sel_ok || (en && (state == HOLD));

  // The mask is captured in the slot's first cycle; bypass it when lighting right after.
  assign mask_eff = (count == '0) ? digit_enable : mask_q;

  slot_counter #(
    .MODULUS(DWELL_CYCLES)
  ) u_slot_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .count(count),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      sel_q   <= SEL_FIRST;
      mask_q  <= '0;
      anode_q <= ANODES_OFF;
      fs_q    <= 1'b0;
    end else begin
      fs_q    <= 1'b0;
      anode_q <= ANODES_OFF;
      if (!sel_ok) begin
        state <= BLANK;
        sel_q <= SEL_FIRST;
      end else if (!en) begin
        state <= HOLD;
      end else begin
        unique case (state)
          HOLD: state <= BLANK;
          BLANK, SHOW: begin
            if (count == '0) begin
              mask_q <= digit_enable;
            end
            if (tc) begin
              state <= BLANK;
              sel_q <= rotate_left(sel_q);
              fs_q  <= sel_q[NUM_DIGITS-1];
            end else if (count >= SHOW_FROM) begin
              state   <= SHOW;
              anode_q <= ~(sel_q & mask_eff);
            end
          end
          default: state <= BLANK;
        endcase
      end
    end
  end

  assign selector    = sel_q;
  assign anode_n     = anode_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a slot/position reference model.
module tb_display_scan_controller;

  localparam int unsigned DWELL = 8;
  localparam int unsigned BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_enable;
  logic [3:0] selector;
  logic [3:0] anode_n;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  // Reference model: which digit owns the slot, position within it, paused flag.
  int         m_digit;
  int         m_pos;
  bit         m_hold;
  bit         m_fs;
  logic [3:0] m_mask;

  display_scan_controller #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digit_enable(digit_enable),
    .selector    (selector),
    .anode_n     (anode_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digit = 0;
    m_pos   = 0;
    m_hold  = 1'b0;
    m_fs    = 1'b0;
    m_mask  = 4'h0;
  endtask

  task automatic model_edge(input bit e, input logic [3:0] d);
    m_fs = 1'b0;
    if (m_hold) begin
      if (e) begin
        m_hold = 1'b0;
        m_pos  = 0;
      end
    end else if (!e) begin
      m_hold = 1'b1;
    end else begin
      if (m_pos == 0) m_mask = d;
      if (m_pos == DWELL - 1) begin
        m_pos   = 0;
        m_fs    = (m_digit == 3);
        m_digit = (m_digit + 1) % 4;
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [3:0] exp_sel();
    return 4'(1 << m_digit);
  endfunction

  function automatic logic [3:0] exp_anode();
    if (!m_hold && m_pos >= int'(BLANK) && m_mask[m_digit]) return ~exp_sel();
    return 4'hf;
  endfunction

  task automatic check_outputs();
    check("selector", 32'(selector), 32'(exp_sel()));
    check("anode_n", 32'(anode_n), 32'(exp_anode()));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("sel_onehot", 32'($onehot(selector)), 32'h1);
    check("one_anode_max", 32'($countones(~anode_n) <= 1), 32'h1);
  endtask

  // Called at a falling edge: apply inputs, advance one clock, compare.
  task automatic cycle(input bit e, input logic [3:0] d);
    en           = e;
    digit_enable = d;
    @(posedge clk);
    model_edge(e, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until(input int dig, input int pos, input logic [3:0] d);
    int n = 0;
    while (!(m_digit == dig && m_pos == pos && !m_hold) && n < 64) begin
      cycle(1'b1, d);
      n++;
    end
    check("reach_position", 32'(n < 64), 32'h1);
  endtask

  initial begin
    logic [3:0] de;
    bit         e;

    rst_n        = 1'b0;
    en           = 1'b1;
    digit_enable = 4'hf;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_selector", 32'(selector), 32'h1);
    check("reset_anode_n", 32'(anode_n), 32'hf);
    check("reset_frame_start", 32'(frame_start), 32'h0);

    // Basic scan: cycle 0 is the half-cycle after release.
    rst_n = 1'b1;
    check_outputs();
    repeat (33) cycle(1'b1, 4'hf);

    // Mask 0101: digits 1 and 3 stay dark while the selector keeps rotating.
    repeat (40) cycle(1'b1, 4'b0101);

    // Mask dropped mid-slot only affects the next slot.
    run_until(3, 0, 4'hf);
    run_until(0, 4, 4'hf);
    repeat (12) cycle(1'b1, 4'h0);

    // Enable gating on digit 2.
    run_until(2, 5, 4'hf);
    repeat (10) cycle(1'b0, 4'hf);
    repeat (20) cycle(1'b1, 4'hf);

    // Asynchronous reset mid-slot on digit 3.
    run_until(3, 6, 4'hf);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_selector", 32'(selector), 32'h1);
    check("async_rst_anode_n", 32'(anode_n), 32'hf);
    check("async_rst_frame_start", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    repeat (40) cycle(1'b1, 4'hf);

    // Upset selector: must reload digit 0 and start a fresh blanked slot.
    run_until(2, 3, 4'hf);
    force dut.sel_q = 4'b0110;
    #1 release dut.sel_q;
    en = 1'b1;
    @(posedge clk);
    model_reset();
    m_mask = 4'hf;
    @(negedge clk);
    check("upset_reload_selector", 32'(selector), 32'h1);
    check("upset_reload_anode_n", 32'(anode_n), 32'hf);
    repeat (12) cycle(1'b1, 4'hf);

    // Randomized enable and mask traffic.
    de = 4'hf;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) de = 4'($urandom);
      cycle(e, de);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
